// File: rtl/climate_pkg.sv
// Shared encodings and defaults for the incubator climate scheduler.
// Latency: none (declarations only); backpressure: not applicable.
package climate_pkg;

    localparam int TEMP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAT  = 3'd1,
        ST_COOL  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_ALARM = 3'd4
    } state_e;

    localparam logic signed [TEMP_W-1:0] HEAT_ON_DEF  = 8'sd20;
    localparam logic signed [TEMP_W-1:0] HEAT_OFF_DEF = 8'sd30;
    localparam logic signed [TEMP_W-1:0] COOL_ON_DEF  = 8'sd35;
    localparam logic signed [TEMP_W-1:0] COOL_OFF_DEF = 8'sd25;
    localparam logic signed [TEMP_W-1:0] ALARM_HI_DEF = 8'sd60;
    localparam logic signed [TEMP_W-1:0] ALARM_LO_DEF = -8'sd10;

    localparam int unsigned MIN_ON_DEF  = 16;
    localparam int unsigned DEAD_DEF    = 4;
    localparam int unsigned ALARM_N_DEF = 8;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/climate_scheduler_if.sv
// Temperature sample, alarm acknowledge and actuator/status outputs of the scheduler.
// Latency: none (wiring only); backpressure: none, T is sampled every clock.
interface climate_scheduler_if;

    logic signed [climate_pkg::TEMP_W-1:0] T;
    logic                                  clear;
    logic                                  Heater;
    logic                                  Cooler;
    logic                                  Alarm;
    logic [2:0]                            State;
    logic [7:0]                            Cycles;

    modport master (
        output T, clear,
        input  Heater, Cooler, Alarm, State, Cycles
    );

    modport slave (
        input  T, clear,
        output Heater, Cooler, Alarm, State, Cycles
    );

endinterface

// File: rtl/climate_scheduler_range_filter.sv
// Counts consecutive out-of-range samples, saturating at n; trip once n is reached.
// Latency: trip one edge after the n-th bad sample; backpressure: none.
module range_filter
    import climate_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [TEMP_W-1:0] t,
    input  logic signed [TEMP_W-1:0] lo,
    input  logic signed [TEMP_W-1:0] hi,
    input  logic [7:0]               n,
    output logic                     trip,
    output logic                     over
);

    logic [7:0] cnt_q, cnt_d;
    logic       over_q, over_d;
    logic       is_hi, is_lo;

    always_comb begin
        is_hi  = t > hi;
        is_lo  = t < lo;
        cnt_d  = 8'd0;
        over_d = over_q;
        if (is_hi || is_lo) begin
            cnt_d  = (cnt_q >= n) ? cnt_q : cnt_q + 8'd1;
            // Direction follows the most recent bad sample.
            over_d = is_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            over_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            over_q <= over_d;
        end
    end

    assign trip = cnt_q >= n;
    assign over = over_q;

endmodule

// File: rtl/climate_scheduler.sv
// Heater/cooler sequencer with min on-time, dead-time gap and filtered alarm override.
// Latency: state follows the T sample one edge later; backpressure: none.
module climate_scheduler
    import climate_pkg::*;
#(
    parameter logic signed [TEMP_W-1:0] HEAT_ON  = HEAT_ON_DEF,
    parameter logic signed [TEMP_W-1:0] HEAT_OFF = HEAT_OFF_DEF,
    parameter logic signed [TEMP_W-1:0] COOL_ON  = COOL_ON_DEF,
    parameter logic signed [TEMP_W-1:0] COOL_OFF = COOL_OFF_DEF,
    parameter logic signed [TEMP_W-1:0] ALARM_HI = ALARM_HI_DEF,
    parameter logic signed [TEMP_W-1:0] ALARM_LO = ALARM_LO_DEF,
    parameter int unsigned              MIN_ON   = MIN_ON_DEF,
    parameter int unsigned              DEAD     = DEAD_DEF,
    parameter int unsigned              ALARM_N  = ALARM_N_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    climate_scheduler_if.slave  bus
);

    localparam logic [7:0] MIN_ON_M1 = 8'(MIN_ON - 1);
    localparam logic [7:0] DEAD_M1   = 8'(DEAD - 1);
    localparam logic [7:0] ALARM_N_L = 8'(ALARM_N);

    state_e                   state_q, state_d;
    logic [7:0]               timer_q, timer_d;
    logic [7:0]               cycles_q, cycles_d;
    logic                     alarm_over_q, alarm_over_d;
    logic signed [TEMP_W-1:0] t_s;
    logic                     in_range;
    logic                     trip, over;
    logic                     entering;
    logic                     heater, cooler, alarm;

    assign t_s      = bus.T;
    assign in_range = (t_s >= ALARM_LO) && (t_s <= ALARM_HI);

    range_filter u_range_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t_s),
        .lo    (ALARM_LO),
        .hi    (ALARM_HI),
        .n     (ALARM_N_L),
        .trip  (trip),
        .over  (over)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_ALARM) begin
            // Leaving ALARM ignores the filter; only an in-range acknowledge releases it.
            if (bus.clear && in_range) state_d = ST_DEAD;
        end else if (trip) begin
            state_d = ST_ALARM;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (t_s > COOL_ON)      state_d = ST_COOL;
                    else if (t_s < HEAT_ON) state_d = ST_HEAT;
                end
                ST_HEAT: if (timer_q >= MIN_ON_M1 && t_s >= HEAT_OFF) state_d = ST_DEAD;
                ST_COOL: if (timer_q >= MIN_ON_M1 && t_s < COOL_OFF)  state_d = ST_DEAD;
                ST_DEAD: if (timer_q == DEAD_M1) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        heater = 1'b0;
        cooler = 1'b0;
        alarm  = 1'b0;
        case (state_q)
            ST_HEAT:  heater = 1'b1;
            ST_COOL:  cooler = 1'b1;
            ST_ALARM: begin
                alarm  = 1'b1;
                cooler = alarm_over_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        entering     = state_d != state_q;
        timer_d      = entering ? 8'd0 : sat_inc(timer_q);
        cycles_d     = (entering && state_d == ST_COOL) ? sat_inc(cycles_q) : cycles_q;
        alarm_over_d = (entering && state_d == ST_ALARM) ? over : alarm_over_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= 8'd0;
            cycles_q     <= 8'd0;
            alarm_over_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            cycles_q     <= cycles_d;
            alarm_over_q <= alarm_over_d;
        end
    end

    assign bus.Heater = heater;
    assign bus.Cooler = cooler;
    assign bus.Alarm  = alarm;
    assign bus.State  = state_q;
    assign bus.Cycles = cycles_q;

endmodule
